tour_cmd: RTL
=============

TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 SHALL have clk  input  1  system clock (50 MHz), all state on rising edge.
REQ-002 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have start_tour  input  1  one-cycle pulse from the tour solver's done; begins replay of the solved tour.
REQ-004 SHALL have move  input  8  one-hot knight move returned by the solver for address mv_indx.
REQ-005 SHALL have mv_indx  output  5  index of the move being replayed, 0..23.
REQ-006 SHALL have cmd_UART  input  16  command from the UART wrapper.
REQ-007 SHALL have cmd_rdy_UART  input  1  UART command valid.
REQ-008 SHALL have clr_cmd_rdy_UART  output  1  acknowledge to the UART wrapper.
REQ-009 SHALL have cmd  output  16  command to the motion/command processor.
REQ-010 SHALL have cmd_rdy  output  1  cmd valid.
REQ-011 SHALL have clr_cmd_rdy  input  1  processor has accepted cmd.
REQ-012 SHALL have send_resp  input  1  processor has finished executing cmd.
REQ-013 SHALL have resp  output  8  response byte returned to the UART.

Function
REQ-014 SHALL implement the states IDLE, VERT, HOLD_V, HORZ and HOLD_H.
REQ-015 IDLE SHALL pass commands through: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy (combinational).
REQ-016 Outside IDLE: clr_cmd_rdy_UART SHALL be 0, and cmd_UART/cmd_rdy_UART SHALL be ignored.
REQ-017 IDLE with start_tour=1 SHALL clear mv_indx to 0 and go to VERT on the next edge.
REQ-018 start_tour SHALL be ignored in every state other than IDLE.
REQ-019 VERT SHALL drive cmd_rdy=1 with the vertical command; clr_cmd_rdy=1 SHALL move it to HOLD_V.
REQ-020 HOLD_V SHALL drive cmd_rdy=0; send_resp=1 SHALL move it to HORZ.
REQ-021 HORZ SHALL drive cmd_rdy=1 with the horizontal command; clr_cmd_rdy=1 SHALL move it to HOLD_H.
REQ-022 HOLD_H with send_resp=1 and mv_indx==23 SHALL go to IDLE.
REQ-023 HOLD_H with send_resp=1 and mv_indx<23 SHALL increment mv_indx and go to VERT.
REQ-024 While cmd_rdy=1 in VERT/HORZ, cmd SHALL be held stable until clr_cmd_rdy; send_resp in VERT/HORZ SHALL be ignored.
REQ-025 Command format SHALL be:
  - [15:12] opcode: 4'h2 = move, 4'h3 = move with fanfare.
  - [11:4] heading: 8'h00 north, 8'h3F west, 8'h7F south, 8'hBF east.
  - [3:0] square count.
REQ-026 The vertical command SHALL be opcode 4'h2 using the move's y offset: north if positive, south if negative, count=|dy|.
REQ-027 The horizontal command SHALL be opcode 4'h3 using the move's x offset: east if positive, west if negative, count=|dx|.
REQ-028 Move to (dx,dy) mapping SHALL be:
  - bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
REQ-029 A non-one-hot move SHALL produce heading 8'h00 and count 0 for both commands, with the sequence continuing unchanged.
REQ-030 move SHALL be sampled combinationally from mv_indx, with mv_indx stable through all four tour states of that move.
REQ-031 resp SHALL be 8'h5A in VERT, HOLD_V and HORZ, and in HOLD_H when mv_indx<23; otherwise 8'hA5.

Reset
REQ-032 rst_n=0 SHALL force IDLE and mv_indx=0 asynchronously, including mid-tour.
REQ-033 After reset, cmd_rdy SHALL equal cmd_rdy_UART (0 when the UART is quiet) and resp SHALL be 8'hA5.
REQ-034 No tour state SHALL survive reset; a new start_tour SHALL be required to replay.

Verification
REQ-035 Reset, then cmd_UART=16'h2005 with cmd_rdy_UART=1 -> cmd=16'h2005, cmd_rdy=1; clr_cmd_rdy=1 -> clr_cmd_rdy_UART=1.
REQ-036 start_tour with move=8'h01 -> cmd=16'h2002 (VERT); after clr/resp handshake -> cmd=16'h3BF1 (HORZ).
REQ-037 move=8'h08 -> vertical 16'h27F1, horizontal 16'h33F2.
REQ-038 Full 24-move replay with a scripted processor model:
  - exactly 48 commands issued, mv_indx advancing 0..23;
  - resp=8'h5A on the first 47 send_resp pulses and 8'hA5 on the 48th;
  - ends in IDLE.
REQ-039 Assert rst_n low during HOLD_V at mv_indx=7 -> immediate IDLE with mv_indx=0; then start_tour restarts the replay at index 0.
REQ-040 Pulse start_tour during HORZ, and pulse send_resp during VERT -> neither changes the state or mv_indx.

Source files
------------

// File: rtl/tour_cmd.sv
// tour_cmd: replays a solved knight's tour as motion commands.
//
// While idle, UART commands pass straight through to the command processor.
// A start_tour pulse takes over the command path and replays 24 moves. Each
// move becomes a vertical command (opcode 2) followed by a horizontal command
// (opcode 3). Each command waits for the processor to accept it and then to
// report that it has finished.
//
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   start_tour        - pulse: begin tour replay (accepted only when idle)
//   move, mv_indx     - one-hot move read combinationally at index mv_indx
//   cmd_UART, cmd_rdy_UART, clr_cmd_rdy_UART - command channel from the UART
//   cmd, cmd_rdy, clr_cmd_rdy, send_resp      - command channel to the processor
//   resp              - response byte: 8'h5A mid-tour, 8'hA5 otherwise
module tour_cmd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] VERT   = 3'd1;
    localparam logic [2:0] HOLD_V = 3'd2;
    localparam logic [2:0] HORZ   = 3'd3;
    localparam logic [2:0] HOLD_H = 3'd4;

    localparam logic [4:0] LAST_IDX = 5'd23;

    localparam logic [7:0] NORTH = 8'h00;
    localparam logic [7:0] WEST  = 8'h3F;
    localparam logic [7:0] SOUTH = 8'h7F;
    localparam logic [7:0] EAST  = 8'hBF;

    localparam logic [7:0] RESP_MID  = 8'h5A;
    localparam logic [7:0] RESP_DONE = 8'hA5;

    logic [2:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  v_head, h_head;
    logic [3:0]  v_cnt, h_cnt;
    logic [15:0] vert_cmd, horz_cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Move decode. Any pattern that is not one-hot falls to the default and
    // yields a zero-length move, so the replay sequence itself is unaffected.
    always_comb begin
        v_head = NORTH;
        v_cnt  = 4'd0;
        h_head = NORTH;
        h_cnt  = 4'd0;
        case (move)
            8'h01: begin v_head = NORTH; v_cnt = 4'd2; h_head = EAST; h_cnt = 4'd1; end
            8'h02: begin v_head = NORTH; v_cnt = 4'd2; h_head = WEST; h_cnt = 4'd1; end
            8'h04: begin v_head = NORTH; v_cnt = 4'd1; h_head = WEST; h_cnt = 4'd2; end
            8'h08: begin v_head = SOUTH; v_cnt = 4'd1; h_head = WEST; h_cnt = 4'd2; end
            8'h10: begin v_head = SOUTH; v_cnt = 4'd2; h_head = WEST; h_cnt = 4'd1; end
            8'h20: begin v_head = SOUTH; v_cnt = 4'd2; h_head = EAST; h_cnt = 4'd1; end
            8'h40: begin v_head = SOUTH; v_cnt = 4'd1; h_head = EAST; h_cnt = 4'd2; end
            8'h80: begin v_head = NORTH; v_cnt = 4'd1; h_head = EAST; h_cnt = 4'd2; end
            default: ;
        endcase
    end

    assign vert_cmd = {4'h2, v_head, v_cnt};
    assign horz_cmd = {4'h3, h_head, h_cnt};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start_tour) begin
                    state_d = VERT;
                    idx_d   = 5'd0;
                end
            end
            VERT:   if (clr_cmd_rdy) state_d = HOLD_V;
            HOLD_V: if (send_resp)   state_d = HORZ;
            HORZ:   if (clr_cmd_rdy) state_d = HOLD_H;
            HOLD_H: begin
                if (send_resp) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        state_d = VERT;
                        idx_d   = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs. In the hold states cmd keeps showing the command just issued;
    // cmd_rdy low is what tells the processor that nothing new is pending.
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        case (state_q)
            VERT, HOLD_V: begin
                cmd              = vert_cmd;
                cmd_rdy          = (state_q == VERT);
                clr_cmd_rdy_UART = 1'b0;
                resp             = RESP_MID;
            end
            HORZ, HOLD_H: begin
                cmd              = horz_cmd;
                cmd_rdy          = (state_q == HORZ);
                clr_cmd_rdy_UART = 1'b0;
                resp = (state_q == HOLD_H && idx_q == LAST_IDX) ? RESP_DONE : RESP_MID;
            end
            default: ;
        endcase
    end

    assign mv_indx = idx_q;

endmodule
